// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ requesters onto one UART transmitter, one word per grant.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic [NUM_REQ-1:0]             o_done,
    output logic [DATA_BITS-1:0]           o_tx_data,
    output logic                           o_tx_write,
    input  logic                           i_tx_busy,
    output logic                           o_active,
    output logic [OWNER_W-1:0]             o_owner
);

    // state | meaning
    // IDLE  | waiting for a request while the transmitter is free
    // START | word written, waiting for the transmitter to raise busy
    // DONE  | transmitter busy, waiting for it to drop to finish the word
    typedef enum logic [1:0] {IDLE, START, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ready;
    logic                   found;
    logic [NUM_REQ-1:0]     win_oh;
    logic [OWNER_W-1:0]     winner;
    logic [DATA_BITS-1:0]   win_data;
    logic                   grant;
    logic [NUM_REQ-1:0]     done_nxt;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req[k]) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
                winner    = OWNER_W'(k);
            end
        end
    end
`else
    logic [OWNER_W-1:0] ptr;

    // Search order i = 0.. visits requester (ptr + i) mod NUM_REQ.
    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && i_req[k] && (k == (int'(ptr) + i) % NUM_REQ)) begin
                    found     = 1'b1;
                    win_oh[k] = 1'b1;
                    winner    = OWNER_W'(k);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= OWNER_W'((int'(winner) + 1) % NUM_REQ);
        end
    end
`endif

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
                win_data = i_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done_nxt  = '0;
        case (state)
            IDLE: begin
                // ready blocks a grant on the first edge after reset release
                if (ready && found && !i_tx_busy) begin
                    grant     = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (i_tx_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_tx_busy) begin
                    state_nxt = IDLE;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (OWNER_W'(k) == o_owner) begin
                            done_nxt[k] = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready      <= 1'b0;
            o_tx_write <= 1'b0;
            o_ack      <= '0;
            o_done     <= '0;
            o_tx_data  <= '0;
            o_owner    <= '0;
        end else begin
            ready      <= 1'b1;
            o_tx_write <= grant;
            o_ack      <= grant ? win_oh : '0;
            o_done     <= done_nxt;
            if (grant) begin
                o_tx_data <= win_data;
                o_owner   <= winner;
            end
        end
    end

    assign o_active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, scoreboard queues and
// hand-written sequences for busy blocking, data isolation and mid-transfer reset.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_BITS = 8;
    localparam int OWNER_W   = 2;

    logic                         i_clk = 1'b0;
    logic                         i_rst_n = 1'b0;
    logic [NUM_REQ-1:0]           i_req = '0;
    logic [NUM_REQ*DATA_BITS-1:0] i_data = '0;
    logic                         i_tx_busy;
    logic [NUM_REQ-1:0]           o_ack;
    logic [NUM_REQ-1:0]           o_done;
    logic [DATA_BITS-1:0]         o_tx_data;
    logic                         o_tx_write;
    logic                         o_active;
    logic [OWNER_W-1:0]           o_owner;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
        .o_ack(o_ack), .o_done(o_done), .o_tx_data(o_tx_data),
        .o_tx_write(o_tx_write), .i_tx_busy(i_tx_busy),
        .o_active(o_active), .o_owner(o_owner)
    );

    always #5 i_clk = ~i_clk;

    // Transmitter model: busy for busy_len cycles after sampling a write.
    int   busy_len = 3;
    int   busy_cnt = 0;
    logic ext_busy = 1'b0;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)               busy_cnt <= 0;
        else if (o_tx_write)        busy_cnt <= busy_len;
        else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    end
    assign i_tx_busy = (busy_cnt != 0) || ext_busy;

    typedef struct { logic [1:0] owner; logic [7:0] data; } exp_t;
    typedef struct { logic [3:0] req; logic [31:0] data; int rr_owner; int fp_owner; } vec_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_writes = 0;
    int   n_dones = 0;
    logic busy_d1 = 1'b0;
    logic busy_d2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int owner, input logic [31:0] data);
        exp_t e;
        logic [31:0] d;
        d       = data;
        e.owner = 2'(owner);
        e.data  = d[owner*8 +: 8];
        return e;
    endfunction

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_tx_write) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(o_tx_write), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_owner", 32'(o_owner), 32'(e.owner));
                    chk("tx_data", 32'(o_tx_data), 32'(e.data));
                    chk("ack_onehot", 32'(o_ack), 32'(1) << e.owner);
                    chk("active_on_write", 32'(o_active), 32'd1);
                    done_q.push_back(int'(e.owner));
                end
            end else if (o_ack != '0) begin
                chk("stray_ack", 32'(o_ack), 32'd0);
            end
            if (o_done != '0) begin
                n_dones++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(o_done), 32'd0);
                end else begin
                    chk("done_onehot", 32'(o_done), 32'(1) << done_q.pop_front());
                    chk("done_timing", 32'({busy_d2, busy_d1}), 32'd2);
                end
            end
        end
        busy_d2 = busy_d1;
        busy_d1 = i_tx_busy;
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wait_writes(input int target, input string what);
        int cyc = 0;
        while (n_writes < target && cyc < 300) begin
            tick();
            cyc++;
        end
        chk(what, 32'(n_writes), 32'(target));
    endtask

    task automatic wait_dones(input int target, input string what);
        int cyc = 0;
        while (n_dones < target && cyc < 300) begin
            tick();
            cyc++;
        end
        chk(what, 32'(n_dones), 32'(target));
    endtask

    task automatic do_grant(input logic [3:0] req, input logic [31:0] data, input int owner);
        int wb = n_writes;
        int db = n_dones;
        exp_q.push_back(mk(owner, data));
        i_data = data;
        i_req  = req;
        wait_writes(wb + 1, "grant_seen");
        i_req = '0;
        wait_dones(db + 1, "done_seen");
        chk("idle_after_done", 32'(o_active), 32'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},    32'(o_ack), 32'd0);
        chk({tag, "_done"},   32'(o_done), 32'd0);
        chk({tag, "_write"},  32'(o_tx_write), 32'd0);
        chk({tag, "_data"},   32'(o_tx_data), 32'd0);
        chk({tag, "_owner"},  32'(o_owner), 32'd0);
        chk({tag, "_active"}, 32'(o_active), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   wb;
        int   db;
        int   own;
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 2};
        vecs[1] = '{4'b0011, 32'h0000_2211, 0, 0};
        vecs[2] = '{4'b1001, 32'h3300_0044, 3, 0};
        vecs[3] = '{4'b1001, 32'h5A00_00C3, 0, 0};
        vecs[4] = '{4'b1110, 32'h0F1E_2D00, 1, 1};
        vecs[5] = '{4'b0110, 32'h00BE_EF00, 2, 1};
        vecs[6] = '{4'b0010, 32'h0000_9900, 1, 1};
        vecs[7] = '{4'b1000, 32'h7E00_0000, 3, 3};

        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        tick();
        i_rst_n = 1'b1;
        repeat (3) tick();

        for (int v = 0; v < 8; v++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            own = vecs[v].fp_owner;
`else
            own = vecs[v].rr_owner;
`endif
            do_grant(vecs[v].req, vecs[v].data, own);
        end

        // Held requests with a slow transmitter.
        busy_len = 10;
        wb = n_writes;
        db = n_dones;
        i_data = 32'hD3C2_B1A0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int g = 0; g < 3; g++) exp_q.push_back(mk(1, i_data));
        i_req = 4'b1010;
        wait_writes(wb + 3, "fp_grants");
        i_req = '0;
        wait_dones(db + 3, "fp_dones");
`else
        for (int g = 0; g < 5; g++) exp_q.push_back(mk(g % 4, i_data));
        i_req = 4'b1111;
        wait_writes(wb + 5, "rr_grants");
        i_req = '0;
        wait_dones(db + 5, "rr_dones");
`endif
        tick();

        // External busy holds off the grant until it drops.
        busy_len = 3;
        ext_busy = 1'b1;
        wb = n_writes;
        db = n_dones;
        i_data = 32'h0000_0077;
        exp_q.push_back(mk(0, i_data));
        i_req = 4'b0001;
        repeat (6) tick();
        chk("busy_blocks_grant", 32'(n_writes), 32'(wb));
        ext_busy = 1'b0;
        @(posedge i_clk);
        #1;
        chk("grant_after_busy", 32'(o_tx_write), 32'd1);
        i_req = '0;
        wait_writes(wb + 1, "busy_grant_seen");
        wait_dones(db + 1, "busy_done_seen");
        tick();

        // Data changes during a transfer; held request becomes the next word.
        busy_len = 10;
        wb = n_writes;
        db = n_dones;
        i_data = 32'h0000_0011;
        exp_q.push_back(mk(0, i_data));
        i_req = 4'b0001;
        wait_writes(wb + 1, "iso_first_grant");
        i_data = 32'h0000_0022;
        exp_q.push_back(mk(0, i_data));
        repeat (6) begin
            tick();
            chk("data_isolation", 32'(o_tx_data), 32'h11);
        end
        wait_writes(wb + 2, "iso_second_grant");
        i_req = '0;
        wait_dones(db + 2, "iso_dones");
        tick();

        // Reset while the transmitter is busy (FSM in DONE).
        wb = n_writes;
        i_data = 32'h0000_0055;
        exp_q.push_back(mk(0, i_data));
        i_req = 4'b0001;
        wait_writes(wb + 1, "rst_pre_grant");
        repeat (3) tick();
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        done_q.delete();
        i_data = 32'h0000_0066;
        repeat (2) tick();
        wb = n_writes;
        db = n_dones;
        exp_q.push_back(mk(0, i_data));
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("no_grant_first_edge", 32'(o_tx_write), 32'd0);
        @(posedge i_clk);
        #1;
        chk("grant_second_edge", 32'(o_tx_write), 32'd1);
        i_req = '0;
        wait_writes(wb + 1, "post_rst_grant");
        wait_dones(db + 1, "post_rst_done");
        repeat (3) tick();

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 4, meaning the number of requesters sharing one transmitter (legal range 1..16).
REQ-002 The block SHALL take parameter DATA_BITS, default 8, meaning the width of each requester's data word, matching the transmitter.
REQ-003 The block SHALL derive OWNER_W = max(1, clog2(NUM_REQ)).
REQ-004 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  NUM_REQ  per-requester transmit request, level.
REQ-007 i_data  input  NUM_REQ*DATA_BITS  packed request data; requester k owns bits [k*DATA_BITS +: DATA_BITS].
REQ-008 o_ack  output  NUM_REQ  one-hot, single-cycle pulse: data of requester k accepted.
REQ-009 o_done  output  NUM_REQ  one-hot, single-cycle pulse: requester k's word finished transmitting.
REQ-010 o_tx_data  output  DATA_BITS  data to transmitter, registered.
REQ-011 o_tx_write  output  1  single-cycle write strobe to transmitter, registered.
REQ-012 i_tx_busy  input  1  transmitter busy flag.
REQ-013 o_active  output  1  high whenever the FSM is not IDLE.
REQ-014 o_owner  output  OWNER_W  index of the current or most recent grantee.

Function
REQ-015 The FSM SHALL have states IDLE, START, DONE.
REQ-016 In IDLE, with any i_req bit high and i_tx_busy low at a clock edge, the FSM SHALL select one winner, register o_tx_data = that requester's slice, o_tx_write = 1, o_ack[winner] = 1, and o_owner = winner, and enter START; both strobes are therefore visible exactly one cycle after the sampling edge.
REQ-017 In IDLE, with i_tx_busy high, no grant SHALL occur regardless of i_req.
REQ-018 o_tx_write and o_ack SHALL be high for exactly one cycle per grant.
REQ-019 In START, the FSM SHALL enter DONE on the first edge at which i_tx_busy = 1.
REQ-020 In DONE, on the first edge at which i_tx_busy = 0, the FSM SHALL pulse o_done[o_owner] for one cycle and return to IDLE.
REQ-021 The next grant SHALL occur no earlier than the edge after the return to IDLE, so the minimum gap between o_tx_write strobes is transmitter busy time + 2 cycles.
REQ-022 A requester SHALL hold i_req and its data stable until its o_ack pulse; a request deasserted before being sampled in IDLE is ignored without error.
REQ-023 i_req[k] held high after o_ack[k] SHALL be treated as a new request for the next word.
REQ-024 i_req changes and i_data changes while in START or DONE SHALL NOT affect o_tx_data, o_owner, or the FSM.
REQ-025 Round-robin pointer: after each grant the pointer SHALL equal (winner+1) mod NUM_REQ.
REQ-026 Round-robin search: the winner SHALL be the first set i_req bit found searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
REQ-027 With NUM_REQ = 1, the block SHALL grant requester 0 whenever the grant conditions hold, and the pointer SHALL remain 0.
REQ-028 o_active SHALL be 1 in START and DONE and 0 in IDLE.

Reset
REQ-029 Assertion of i_rst_n low SHALL immediately force IDLE, pointer 0, o_ack = 0, o_done = 0, o_tx_write = 0, o_tx_data = 0, o_owner = 0, and o_active = 0, independent of i_clk.
REQ-030 Reset mid-transfer SHALL discard the in-flight grant without an o_done pulse; requesters re-request after release.
REQ-031 The first grant after release SHALL occur no earlier than the second rising edge after i_rst_n goes high.

Configuration
REQ-032 With macro UART_ARB_FIXED_PRIO_EN defined, the winner SHALL be the lowest-index set i_req bit and the pointer SHALL be unused.
REQ-033 Without UART_ARB_FIXED_PRIO_EN, round-robin per REQ-025/REQ-026 SHALL apply.

Verification
REQ-034 Single request: NUM_REQ=4, i_req=4'b0100, data2=8'hA5, busy idle -> o_tx_write and o_ack=4'b0100 one cycle later, o_tx_data=8'hA5, o_owner=2; o_done=4'b0100 one cycle after busy falls.
REQ-035 Round-robin fairness: i_req=4'b1111 held, transmitter model busy 10 cycles -> grant order 0,1,2,3,0; each o_ack a single cycle.
REQ-036 Fixed priority (UART_ARB_FIXED_PRIO_EN defined): i_req=4'b1010 held -> grants 1,1,1; requester 3 never granted while bit 1 is set.
REQ-037 External busy: i_tx_busy forced high in IDLE with i_req=4'b0001 -> no o_tx_write until busy low; then grant on the next edge.
REQ-038 Reset mid-transfer: i_rst_n low during DONE -> all outputs 0 immediately, no o_done; after release, a pending request to requester 0 is granted and owner=0.
REQ-039 Data isolation: change data0 from 8'h11 to 8'h22 during START -> o_tx_data stays 8'h11 until the next grant.
